uart_tx_sched: RTL and testbench

Frame scheduler for the UART frame serializer: it shares one serializer between `N_REQ` requesters with round-robin arbitration, presents each granted frame's data, width and parity configuration to the serializer, and gates the serializer's run enable so the line idles high whenever no frame is pending. It sits between the register/DMA request sources and the serializer, in the serializer's bit-clock domain.

---
 rtl/uart_tx_sched.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Frame scheduler in front of a single UART serializer. Requesters are served
// round-robin. The granted frame's data/width/parity are held on tx_* for the
// whole frame, and tx_run gates the serializer so the line idles high
// whenever no frame is in flight.
//
// Ports
//   clock, reset      bit-rate clock; asynchronous active-high reset
//   req_valid[k]      requester k has a frame pending
//   req_ready[k]      one-hot accept (combinational); transfer on valid&ready
//   req_data          16 bits per requester, LSB sent first
//   req_width         4 bits per requester, data bits 1..15 (0 = dropped)
//   req_parity        2 bits per requester: 0/1 none, 2 even, 3 odd
//   tx_run            serializer enable (0 holds serializer in reset, line high)
//   tx_bits/width/parity  configuration of the frame in flight
//   tx_need_load      serializer stop-bit indication (consistency check only)
//   busy              scheduler not idle
//   grant_id          index of the last requester whose frame was started
//   drop_err          one-cycle pulse when a width-0 request is consumed
//   sync_err          one-cycle pulse on serializer/scheduler phase mismatch
module uart_tx_sched #(
  parameter int N_REQ      = 4,
  parameter int IDLE_GUARD = 1,
  localparam int IDW       = $clog2(N_REQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [16*N_REQ-1:0]  req_data,
  input  logic [4*N_REQ-1:0]   req_width,
  input  logic [2*N_REQ-1:0]   req_parity,
  output logic                 tx_run,
  output logic [15:0]          tx_bits,
  output logic [3:0]           tx_width,
  output logic [1:0]           tx_parity,
  input  logic                 tx_need_load,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 drop_err,
  output logic                 sync_err
);

  typedef enum logic [1:0] {IDLE, RUN, GUARD} state_t;

  state_t         state_reg, state_next;
  logic [4:0]     cnt_reg, cnt_next;
  logic [4:0]     cnt_load_reg, cnt_load_next;
  logic [3:0]     guard_reg, guard_next;
  logic [IDW-1:0] ptr_reg, ptr_next;
  logic           tx_run_reg, tx_run_next;
  logic [15:0]    tx_bits_reg, tx_bits_next;
  logic [3:0]     tx_width_reg, tx_width_next;
  logic [1:0]     tx_parity_reg, tx_parity_next;
  logic [IDW-1:0] grant_reg, grant_next;
  logic           drop_reg, drop_next;
  logic           sync_reg, sync_next;

  // Per-requester views of the flattened request buses.
  logic [15:0]    data_arr  [N_REQ];
  logic [3:0]     width_arr [N_REQ];
  logic [1:0]     par_arr   [N_REQ];
  // cand_idx[i] is the requester with the i-th highest priority this cycle.
  logic [IDW:0]   cand_sum  [N_REQ];
  logic [IDW-1:0] cand_idx  [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign data_arr[gi]  = req_data[16*gi +: 16];
    assign width_arr[gi] = req_width[4*gi +: 4];
    assign par_arr[gi]   = req_parity[2*gi +: 2];
    assign cand_sum[gi]  = {1'b0, ptr_reg} + (IDW+1)'(gi);
    assign cand_idx[gi]  = (cand_sum[gi] >= (IDW+1)'(N_REQ))
                           ? IDW'(cand_sum[gi] - (IDW+1)'(N_REQ))
                           : cand_sum[gi][IDW-1:0];
  end

  logic           win_found;
  logic [IDW-1:0] win_idx;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[cand_idx[i]]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[i];
      end
    end
  end

  logic [15:0]    win_data;
  logic [3:0]     win_width;
  logic [1:0]     win_par;
  logic           win_legal;
  logic [4:0]     win_len;
  logic [IDW-1:0] ptr_adv;
  logic           sync_det;
  logic           accept_slot;
  logic           take;

  assign win_data  = data_arr[win_idx];
  assign win_width = width_arr[win_idx];
  assign win_par   = par_arr[win_idx];
  assign win_legal = (win_width != 4'd0);
  // Cycles left after the accept edge until the stop-bit edge.
  assign win_len   = 5'(win_width) + {4'd0, win_par[1]} + 5'd1;
  assign ptr_adv   = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  // The serializer reporting its stop bit at any point other than the first
  // cycle of a frame means the two have drifted apart.
  assign sync_det    = (state_reg == RUN) && tx_need_load && (cnt_reg != cnt_load_reg);
  // A mismatch at the stop-bit edge blocks the back-to-back accept, so no
  // request is consumed in that cycle. Nothing is offered while in reset.
  assign accept_slot = !reset && ((state_reg == IDLE) ||
                       ((state_reg == RUN) && (cnt_reg == 5'd0) && !sync_det));
  assign take        = accept_slot && win_found;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready[gi] = take && (win_idx == IDW'(gi));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cnt_load_reg  <= '0;
      guard_reg     <= '0;
      ptr_reg       <= '0;
      tx_run_reg    <= 1'b0;
      tx_bits_reg   <= '0;
      tx_width_reg  <= '0;
      tx_parity_reg <= '0;
      grant_reg     <= '0;
      drop_reg      <= 1'b0;
      sync_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cnt_load_reg  <= cnt_load_next;
      guard_reg     <= guard_next;
      ptr_reg       <= ptr_next;
      tx_run_reg    <= tx_run_next;
      tx_bits_reg   <= tx_bits_next;
      tx_width_reg  <= tx_width_next;
      tx_parity_reg <= tx_parity_next;
      grant_reg     <= grant_next;
      drop_reg      <= drop_next;
      sync_reg      <= sync_next;
    end
  end

  logic start_frame;
  logic stop_frame;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    cnt_load_next  = cnt_load_reg;
    guard_next     = guard_reg;
    ptr_next       = ptr_reg;
    tx_run_next    = tx_run_reg;
    tx_bits_next   = tx_bits_reg;
    tx_width_next  = tx_width_reg;
    tx_parity_next = tx_parity_reg;
    grant_next     = grant_reg;
    drop_next      = 1'b0;
    sync_next      = 1'b0;
    start_frame    = 1'b0;
    stop_frame     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (take) begin
          ptr_next = ptr_adv;
          if (win_legal) start_frame = 1'b1;
          else           drop_next   = 1'b1;
        end
      end
      RUN: begin
        if (sync_det) begin
          sync_next  = 1'b1;
          stop_frame = 1'b1;
        end else if (cnt_reg == 5'd0) begin
          if (take) begin
            ptr_next = ptr_adv;
            if (win_legal) begin
              start_frame = 1'b1;
            end else begin
              drop_next  = 1'b1;
              stop_frame = 1'b1;
            end
          end else begin
            stop_frame = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - 5'd1;
        end
      end
      GUARD: begin
        if (guard_reg == 4'd0) state_next = IDLE;
        else                   guard_next = guard_reg - 4'd1;
      end
      default: state_next = IDLE;
    endcase

    if (start_frame) begin
      state_next     = RUN;
      tx_run_next    = 1'b1;
      tx_bits_next   = win_data;
      tx_width_next  = win_width;
      tx_parity_next = win_par;
      cnt_next       = win_len;
      cnt_load_next  = win_len;
      grant_next     = win_idx;
    end
    if (stop_frame) begin
      state_next  = GUARD;
      tx_run_next = 1'b0;
      guard_next  = 4'(IDLE_GUARD);
    end
  end

  assign tx_run    = tx_run_reg;
  assign tx_bits   = tx_bits_reg;
  assign tx_width  = tx_width_reg;
  assign tx_parity = tx_parity_reg;
  assign busy      = (state_reg != IDLE);
  assign grant_id  = grant_reg;
  assign drop_err  = drop_reg;
  assign sync_err  = sync_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched. A timeline model predicts, per cycle, which
// request is consumed and what the scheduler outputs should be; predicted
// handshakes go into a queue that a negedge monitor drains and compares.
module tb_uart_tx_sched;
  localparam int NR  = 4;
  localparam int GD  = 1;
  localparam int IDW = $clog2(NR);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [16*NR-1:0]  req_data = '0;
  logic [4*NR-1:0]   req_width = '0;
  logic [2*NR-1:0]   req_parity = '0;
  logic              tx_run;
  logic [15:0]       tx_bits;
  logic [3:0]        tx_width;
  logic [1:0]        tx_parity;
  logic              tx_need_load = 1'b0;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic              drop_err;
  logic              sync_err;

  uart_tx_sched #(.N_REQ(NR), .IDLE_GUARD(GD)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_width(req_width), .req_parity(req_parity),
    .tx_run(tx_run), .tx_bits(tx_bits), .tx_width(tx_width), .tx_parity(tx_parity),
    .tx_need_load(tx_need_load), .busy(busy), .grant_id(grant_id),
    .drop_err(drop_err), .sync_err(sync_err)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [15:0] data; logic [3:0] width; logic [1:0] par; } frame_t;
  typedef struct packed { int cyc; int rid; } hs_t;

  frame_t pend [NR];
  bit     has  [NR];
  hs_t    exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mon_en   = 0;

  int refill_pct  = 0;
  int zero_pct    = 0;
  int nl_permille = 0;

  // Timeline model: cycle indices at which the frame ends, busy ends, etc.
  bit          m_framing = 0;
  int          m_idle_from = 0;
  int          m_slot = 0;
  int          m_acc = 0;
  int          m_run_until = -1;
  int          m_busy_until = -1;
  int          m_ptr = 0;
  logic [15:0] m_bits = '0;
  logic [3:0]  m_width = '0;
  logic [1:0]  m_par = '0;
  int          m_gid = 0;
  bit          m_drop = 0;
  bit          m_sync = 0;

  // Expectations for the current cycle, read by the monitor.
  bit          exp_run, exp_busy, exp_drop, exp_sync;
  logic [15:0] exp_bits;
  logic [3:0]  exp_width;
  logic [1:0]  exp_par;
  int          exp_gid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    f.data  = 16'($urandom);
    f.width = ($urandom_range(99) < 32'(zero_pct)) ? 4'd0 : 4'($urandom_range(15, 1));
    f.par   = 2'($urandom_range(3));
    return f;
  endfunction

  task automatic end_frame(input int c);
    m_framing    = 0;
    m_run_until  = c;
    m_busy_until = c + GD + 1;
    m_idle_from  = c + GD + 2;
  endtask

  task automatic model_reset();
    m_framing = 0; m_idle_from = cyc + 1; m_run_until = -1; m_busy_until = -1;
    m_ptr = 0; m_bits = '0; m_width = '0; m_par = '0; m_gid = 0;
    m_drop = 0; m_sync = 0;
  endtask

  task automatic step();
    int w;
    int len;
    @(posedge clock);
    #1;
    cyc++;
    for (int k = 0; k < NR; k++) begin
      if (!has[k] && $urandom_range(99) < 32'(refill_pct)) begin
        pend[k] = rand_frame();
        has[k]  = 1;
      end
      req_valid[k]             = has[k];
      req_data[16*k +: 16]     = pend[k].data;
      req_width[4*k +: 4]      = pend[k].width;
      req_parity[2*k +: 2]     = pend[k].par;
    end
    tx_need_load = ($urandom_range(999) < 32'(nl_permille));

    exp_run   = (cyc <= m_run_until);
    exp_busy  = (cyc <= m_busy_until);
    exp_bits  = m_bits;
    exp_width = m_width;
    exp_par   = m_par;
    exp_gid   = m_gid;
    exp_drop  = m_drop;
    exp_sync  = m_sync;
    m_drop = 0;
    m_sync = 0;

    // Only the first cycle of a frame may legitimately see the stop-bit flag.
    if (m_framing && tx_need_load && cyc != m_acc + 1) begin
      m_sync = 1;
      end_frame(cyc);
    end else if ((!m_framing && cyc >= m_idle_from) || (m_framing && cyc == m_slot)) begin
      w = -1;
      for (int i = 0; i < NR; i++)
        if (w < 0 && has[(m_ptr + i) % NR]) w = (m_ptr + i) % NR;
      if (w >= 0) begin
        exp_q.push_back('{cyc: cyc, rid: w});
        has[w] = 0;
        m_ptr  = (w + 1) % NR;
        if (pend[w].width != 4'd0) begin
          len          = int'(pend[w].width) + int'(pend[w].par[1]) + 2;
          m_framing    = 1;
          m_acc        = cyc;
          m_slot       = cyc + len;
          m_run_until  = cyc + len;
          m_busy_until = cyc + len;
          m_bits       = pend[w].data;
          m_width      = pend[w].width;
          m_par        = pend[w].par;
          m_gid        = w;
        end else begin
          m_drop = 1;
          if (m_framing) end_frame(cyc);
        end
      end else if (m_framing) begin
        end_frame(cyc);
      end
    end
    mon_en = 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor / scoreboard
  logic [NR-1:0] mon_exp_hs;
  hs_t           mon_h;
  always @(negedge clock) begin
    if (mon_en) begin
      mon_exp_hs = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_h = exp_q.pop_front();
        mon_exp_hs[mon_h.rid] = 1'b1;
        $display("cycle %0d: request %0d consumed (width %0d)", cyc, mon_h.rid, req_width[4*mon_h.rid +: 4]);
      end
      check("handshake", 32'(req_ready & req_valid), 32'(mon_exp_hs));
      check("tx_run",    32'(tx_run),    32'(exp_run));
      check("busy",      32'(busy),      32'(exp_busy));
      check("tx_bits",   32'(tx_bits),   32'(exp_bits));
      check("tx_width",  32'(tx_width),  32'(exp_width));
      check("tx_parity", 32'(tx_parity), 32'(exp_par));
      check("grant_id",  32'(grant_id),  32'(exp_gid));
      check("drop_err",  32'(drop_err),  32'(exp_drop));
      check("sync_err",  32'(sync_err),  32'(exp_sync));
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_run"},    32'(tx_run),    32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_tx_bits"},   32'(tx_bits),   32'd0);
    check({tag, "_tx_width"},  32'(tx_width),  32'd0);
    check({tag, "_tx_parity"}, 32'(tx_parity), 32'd0);
    check({tag, "_grant_id"},  32'(grant_id),  32'd0);
    check({tag, "_drop_err"},  32'(drop_err),  32'd0);
    check({tag, "_sync_err"},  32'(sync_err),  32'd0);
  endtask

  initial begin
    bit found;
    for (int k = 0; k < NR; k++) begin
      has[k]  = 0;
      pend[k] = '0;
    end
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Single frame: 0x00A5, 8 bits, even parity -> 11 cycles of tx_run.
    pend[0] = '{data: 16'h00A5, width: 4'd8, par: 2'd2}; has[0] = 1;
    run(30);

    // Back-to-back frames from requesters 1 and 2.
    pend[1] = '{data: 16'h0013, width: 4'd5, par: 2'd0}; has[1] = 1;
    pend[2] = '{data: 16'h001C, width: 4'd5, par: 2'd0}; has[2] = 1;
    run(30);

    // Fairness: all requesters continuously valid.
    refill_pct = 100;
    for (int k = 0; k < NR; k++) begin
      pend[k] = rand_frame();
      has[k]  = 1;
    end
    run(160);
    refill_pct = 0;
    run(100);

    // Width-0 request, then a normal one.
    pend[3] = '{data: 16'h1234, width: 4'd0, par: 2'd0}; has[3] = 1;
    run(5);
    pend[0] = '{data: 16'h0155, width: 4'd9, par: 2'd3}; has[0] = 1;
    run(40);

    // Randomized traffic including drops and phase mismatches.
    refill_pct = 25; zero_pct = 8; nl_permille = 20;
    run(3000);

    // Reset in the middle of a frame.
    refill_pct = 100; zero_pct = 0; nl_permille = 0;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (m_framing && cyc == m_acc + 5 && m_slot > cyc + 1) found = 1;
    end
    check("reset_point_reached", 32'(found), 32'd1);
    mon_en = 0;
    #2;
    reset = 1'b1;
    req_valid = '0;
    #1;
    check_all_zero("midframe_reset");
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    run(80);

    refill_pct = 0;
    run(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
